// File: rtl/tsi_switch_param.sv
// Purpose : parametrised time slot interchange; any output (stream, slot) takes any input (stream, slot) of the previous frame.
// Latency : one frame plus one clock from input bit to output bit; stream_out is registered.
// Backpressure: none; input_valid low stalls counters, shift registers and outputs in place.
//
// Ports:
//   clk, reset               single rising-edge clock, synchronous active-high reset
//   input_valid, stream_in   qualified serial TDM inputs, one bit per stream, LSB first
//   control_write/addr/data  shadow connection-map write (entry = out_stream*SLOTS + out_slot)
//   ctrl_commit              request shadow -> active copy at the next frame boundary
//   commit_pending           copy requested but not yet done
//   frame_sync               high while bit 0 of slot 0 is on stream_out
//   stream_out               switched serial outputs, LSB first
module tsi_switch_param #(
    parameter int         N_STREAMS    = 8,
    parameter int         SLOTS        = 32,
    parameter int         SLOT_BITS    = 8,
    parameter logic [7:0] IDLE_PATTERN = 8'hFF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               input_valid,
    input  logic [N_STREAMS-1:0]               stream_in,
    input  logic                               control_write,
    input  logic [$clog2(N_STREAMS*SLOTS)-1:0] control_addr,
    input  logic [15:0]                        control_data,
    input  logic                               ctrl_commit,
    output logic                               commit_pending,
    output logic                               frame_sync,
    output logic [N_STREAMS-1:0]               stream_out
);

    localparam int ENTRIES   = N_STREAMS * SLOTS;
    localparam int ADDR_W    = $clog2(ENTRIES);
    localparam int SLOT_W    = $clog2(SLOTS);
    localparam int BIT_W     = $clog2(SLOT_BITS);
    // Speech memory is addressed {bank, stream*SLOTS + slot}; rounding the
    // per-bank half up to a power of two keeps that concatenation in range.
    localparam int MEM_DEPTH = 2 ** (ADDR_W + 1);
    localparam logic [15:0]          IDLE_EXT  = {8'h00, IDLE_PATTERN};
    localparam logic [SLOT_BITS-1:0] IDLE_WORD = IDLE_EXT[SLOT_BITS-1:0];

    // Frame position, split into slot and bit so SLOT_BITS need not be a power of two.
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              bank_q, bank_d;
    logic              primed_q, primed_d;
    logic              pending_q, pending_d;
    logic              sync_q, sync_d;
    logic [N_STREAMS-1:0] out_q;
    logic [SLOT_BITS-2:0] out_sh_q [N_STREAMS];
    logic [SLOT_BITS-2:0] in_sh_q  [N_STREAMS];
    logic [SLOT_BITS-1:0] speech_q [MEM_DEPTH];
    logic [15:0]          shadow_q [ENTRIES];
    logic [15:0]          active_q [ENTRIES];
    logic [SLOT_BITS-1:0] load_word [N_STREAMS];

    logic slot_start, slot_end, frame_end, do_copy, wr_ok;

    assign slot_start = (bit_q == '0);
    assign slot_end   = (bit_q == BIT_W'(SLOT_BITS - 1));
    assign frame_end  = input_valid && slot_end && (slot_q == SLOT_W'(SLOTS - 1));
    assign wr_ok      = control_write && ({1'b0, control_addr} < (ADDR_W + 1)'(ENTRIES));

    // Copy at the frame wrap (a commit arriving on the wrap cycle counts), or
    // while parked at position 0 with a commit already pending, so the next
    // frame still starts on the new map.
    assign do_copy = (frame_end && (pending_q || ctrl_commit)) ||
                     (!input_valid && slot_start && (slot_q == '0) && pending_q);

    always_comb begin
        bit_d     = bit_q;
        slot_d    = slot_q;
        bank_d    = bank_q;
        primed_d  = primed_q;
        sync_d    = 1'b0;
        pending_d = (pending_q || ctrl_commit) && !do_copy;
        if (input_valid) begin
            sync_d = slot_start && (slot_q == '0);
            if (slot_end) begin
                bit_d  = '0;
                slot_d = slot_q + 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
            end
            if (frame_end) begin
                bank_d   = ~bank_q;
                primed_d = 1'b1;
            end
        end
    end

    // Per-output word fetch from the read bank (the frame before the one being written).
    for (genvar o = 0; o < N_STREAMS; o++) begin : g_rd
        logic [ADDR_W-1:0] ent_idx;
        logic              en;
        logic [5:0]        src_st;
        logic [7:0]        src_sl;
        logic              src_ok;
        logic [ADDR_W:0]   rd_idx;

        assign ent_idx = ADDR_W'(o * SLOTS) + ADDR_W'(slot_q);
        assign en      = active_q[ent_idx][15];
        assign src_st  = active_q[ent_idx][13:8];
        assign src_sl  = active_q[ent_idx][7:0];
        assign src_ok  = en && primed_q && (int'(src_st) < N_STREAMS) && (int'(src_sl) < SLOTS);
        assign rd_idx  = {~bank_q, ADDR_W'(int'(src_st) * SLOTS + int'(src_sl))};
        assign load_word[o] = src_ok ? speech_q[rd_idx] : IDLE_WORD;
    end

    // Input assembly and speech memory write; contents need no reset.
    always_ff @(posedge clk) begin
        if (input_valid && !reset) begin
            for (int s = 0; s < N_STREAMS; s++) begin
                in_sh_q[s] <= (in_sh_q[s] >> 1) |
                              ((SLOT_BITS - 1)'(stream_in[s]) << (SLOT_BITS - 2));
                if (slot_end) begin
                    speech_q[{bank_q, ADDR_W'(s * SLOTS) + ADDR_W'(slot_q)}] <= {stream_in[s], in_sh_q[s]};
                end
            end
        end
    end

    // Shadow/active connection maps. A write on the copy cycle is folded into the copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int e = 0; e < ENTRIES; e++) begin
                shadow_q[e] <= '0;
                active_q[e] <= '0;
            end
        end else begin
            if (wr_ok) begin
                shadow_q[control_addr] <= control_data;
            end
            if (do_copy) begin
                for (int e = 0; e < ENTRIES; e++) begin
                    active_q[e] <= (wr_ok && (control_addr == ADDR_W'(e))) ? control_data : shadow_q[e];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_q     <= '0;
            slot_q    <= '0;
            bank_q    <= 1'b0;
            primed_q  <= 1'b0;
            pending_q <= 1'b0;
            sync_q    <= 1'b0;
            out_q     <= '0;
            for (int o = 0; o < N_STREAMS; o++) begin
                out_sh_q[o] <= '0;
            end
        end else begin
            bit_q     <= bit_d;
            slot_q    <= slot_d;
            bank_q    <= bank_d;
            primed_q  <= primed_d;
            pending_q <= pending_d;
            sync_q    <= sync_d;
            if (input_valid) begin
                for (int o = 0; o < N_STREAMS; o++) begin
                    if (slot_start) begin
                        out_q[o]    <= load_word[o][0];
                        out_sh_q[o] <= load_word[o][SLOT_BITS-1:1];
                    end else begin
                        out_q[o]    <= out_sh_q[o][0];
                        out_sh_q[o] <= out_sh_q[o] >> 1;
                    end
                end
            end
        end
    end

    assign commit_pending = pending_q;
    assign frame_sync     = sync_q;
    assign stream_out     = out_q;

endmodule

// File: tb/tb_tsi_switch_param.sv
// Purpose : randomized scoreboard bench for tsi_switch_param (8 streams, 32 slots, 8 bits).
// Latency : expected slots queued at each input frame start, popped as output slots complete.
// Backpressure: stall cycles are injected; the monitor expects stream_out to hold while stalled.
module tb_tsi_switch_param;

    logic        clk;
    logic        reset;
    logic        input_valid;
    logic [7:0]  stream_in;
    logic        control_write;
    logic [7:0]  control_addr;
    logic [15:0] control_data;
    logic        ctrl_commit;
    logic        commit_pending;
    logic        frame_sync;
    logic [7:0]  stream_out;

    tsi_switch_param #(
        .N_STREAMS(8), .SLOTS(32), .SLOT_BITS(8), .IDLE_PATTERN(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .input_valid(input_valid), .stream_in(stream_in),
        .control_write(control_write), .control_addr(control_addr),
        .control_data(control_data), .ctrl_commit(ctrl_commit),
        .commit_pending(commit_pending), .frame_sync(frame_sync), .stream_out(stream_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  cur  [8][32];
    logic [7:0]  prev [8][32];
    logic [15:0] sh   [256];
    logic [15:0] act  [256];
    logic        primed;
    logic        pend;
    logic        exp_pend;
    int          pos;
    logic [63:0] expq [$];
    logic [23:0] wq [$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Output word for each stream in output slot s, straight from the map rules.
    function automatic logic [63:0] exp_slot(int s);
        logic [63:0] r;
        logic [15:0] e;
        int ss, sl;
        r = '0;
        for (int o = 0; o < 8; o++) begin
            e  = act[o * 32 + s];
            ss = int'(e[13:8]);
            sl = int'(e[7:0]);
            if (primed && e[15] && ss < 8 && sl < 32) r[o*8 +: 8] = prev[ss][sl];
            else                                      r[o*8 +: 8] = 8'hFF;
        end
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input logic wr, input logic [7:0] a,
                               input logic [15:0] d, input logic cm);
        logic old;
        logic copy;
        @(negedge clk);
        reset         = 1'b0;
        input_valid   = v;
        control_write = wr;
        control_addr  = a;
        control_data  = d;
        ctrl_commit   = cm;
        for (int st = 0; st < 8; st++)
            stream_in[st] = v ? cur[st][pos / 8][pos % 8] : 1'($urandom);
        if (v && pos == 0)
            for (int s = 0; s < 32; s++) expq.push_back(exp_slot(s));
        if (wr) sh[a] = d;
        old  = pend;
        pend = pend | cm;
        copy = v ? (pos == 255 && pend) : (pos == 0 && old);
        if (copy) begin
            act  = sh;
            pend = 1'b0;
        end
        if (v) begin
            if (pos == 255) begin
                prev   = cur;
                primed = 1'b1;
            end
            pos = (pos + 1) % 256;
        end
        exp_pend = pend;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; input_valid = 1'b0; control_write = 1'b0; ctrl_commit = 1'b0;
        pos = 0; pend = 1'b0; exp_pend = 1'b0; primed = 1'b0;
        for (int e = 0; e < 256; e++) begin
            sh[e]  = '0;
            act[e] = '0;
        end
        expq.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic program_base();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 8'(i), 16'h8000 | 16'(i), 1'b0);
        drive_cycle(1'b0, 1'b1, 8'd32,  16'h8105, 1'b0);   // out1 slot0 <- in1 slot5
        drive_cycle(1'b0, 1'b1, 8'd71,  16'h8105, 1'b0);   // broadcast to out2/3/4 slot7
        drive_cycle(1'b0, 1'b1, 8'd103, 16'h8105, 1'b0);
        drive_cycle(1'b0, 1'b1, 8'd135, 16'h8105, 1'b0);
        drive_cycle(1'b0, 1'b1, 8'd161, 16'h0003, 1'b0);   // disabled
        drive_cycle(1'b0, 1'b1, 8'd162, 16'h8A00, 1'b0);   // source stream 10
        drive_cycle(1'b0, 1'b1, 8'd163, 16'h8028, 1'b0);   // source slot 40
        for (int i = 0; i < 16; i++)
            drive_cycle(1'b0, 1'b1, 8'(192 + $urandom_range(0, 63)),
                        {2'b10, 6'($urandom_range(0, 7)), 8'($urandom_range(0, 31))}, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
    endtask

    task automatic run_frame(input int stall_pos, input int commit_pos, input int reset_pos,
                             input int wr_start);
        logic        w;
        logic [23:0] ent;
        for (int st = 0; st < 8; st++)
            for (int s = 0; s < 32; s++) cur[st][s] = 8'($urandom);
        cur[0][0] = 8'h11; cur[0][1] = 8'h22; cur[0][2] = 8'h33; cur[0][3] = 8'h44;
        cur[1][5] = 8'hA4;
        for (int p = 0; p < 256; p++) begin
            if (p == reset_pos) begin
                do_reset();
                return;
            end
            if (p == stall_pos) repeat (7) drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
            w   = 1'b0;
            ent = '0;
            if (p >= wr_start && wq.size() > 0) begin
                w   = 1'b1;
                ent = wq.pop_front();
            end
            drive_cycle(1'b1, w, ent[23:16], ent[15:0], p == commit_pos);
        end
    endtask

    // Monitor: checks every cycle against the queued expectations.
    initial begin : monitor
        logic [63:0] acc;
        logic [63:0] e;
        logic [7:0]  last_out;
        logic        v, r;
        int          mpos, b;
        acc = '0; last_out = '0; mpos = 0;
        forever begin
            @(posedge clk);
            v = input_valid;
            r = reset;
            #1;
            if (r) begin
                mpos = 0;
                chk("reset_out",  64'(stream_out), 64'h0);
                chk("reset_sync", 64'(frame_sync), 64'h0);
                chk("reset_pend", 64'(commit_pending), 64'h0);
            end else begin
                chk("pending", 64'(commit_pending), 64'(exp_pend));
                if (v) begin
                    chk("frame_sync", 64'(frame_sync), 64'(mpos == 0));
                    b = mpos % 8;
                    for (int st = 0; st < 8; st++) acc[st * 8 + b] = stream_out[st];
                    if (b == 7) begin
                        if (expq.size() == 0) begin
                            n_checks++;
                            n_err++;
                            $display("FAIL slot_queue: output slot %0d with no expectation", mpos / 8);
                        end else begin
                            e = expq.pop_front();
                            chk($sformatf("slot%0d", mpos / 8), acc, e);
                        end
                    end
                    mpos = (mpos + 1) % 256;
                end else begin
                    chk("stall_hold", 64'(stream_out), 64'(last_out));
                    chk("stall_sync", 64'(frame_sync), 64'h0);
                end
            end
            last_out = stream_out;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1; input_valid = 1'b0; stream_in = '0; control_write = 1'b0;
        control_addr = '0; control_data = '0; ctrl_commit = 1'b0;
        pos = 0; pend = 1'b0; exp_pend = 1'b0; primed = 1'b0;
        for (int st = 0; st < 8; st++)
            for (int s = 0; s < 32; s++) begin
                cur[st][s]  = '0;
                prev[st][s] = '0;
            end
        do_reset();
        program_base();
        run_frame(-1, -1, -1, 0);       // unprimed: all idle pattern
        run_frame(-1, -1, -1, 0);       // identity, cross-connect, broadcast, invalid
        // New map written mid-frame, committed at bit 100, live from next frame
        wq.push_back({8'd0, 16'h8103}); wq.push_back({8'd1, 16'h8102});
        wq.push_back({8'd2, 16'h8101}); wq.push_back({8'd3, 16'h8100});
        wq.push_back({8'd32, 16'h8000}); wq.push_back({8'd71, 16'h8003});
        run_frame(-1, 100, -1, 50);
        // Stall mid-slot; write and commit together on the wrap cycle
        wq.push_back({8'd33, 16'h8007});
        run_frame(43, 255, -1, 255);
        // Commit while parked at the frame boundary
        drive_cycle(1'b0, 1'b1, 8'd34, 16'h8011, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b1);
        drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        run_frame(-1, -1, -1, 0);
        // Pending commit at bit 20 dropped by reset at bit 77
        wq.push_back({8'd0, 16'h8107});
        run_frame(-1, 20, 77, 10);
        wq.delete();
        program_base();
        run_frame(-1, -1, -1, 0);       // unprimed again
        run_frame(-1, -1, -1, 0);       // switching restored
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 5; i++)
                wq.push_back({8'($urandom), 1'b1, 1'($urandom), 6'($urandom_range(0, 9)),
                              8'($urandom_range(0, 35))});
            run_frame($urandom_range(1, 254), $urandom_range(0, 255), -1, $urandom_range(0, 200));
        end
        repeat (3) drive_cycle(1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tsi_switch_param.md
Name: tsi_switch_param

Overview:
- Parametrised next-generation time slot interchange switch.
- N_STREAMS serial TDM input streams each carry SLOTS slots of SLOT_BITS bits per frame, sent LSB first at one bit per valid clock.
- Any output (stream, slot) can be driven from any input (stream, slot) of the previous frame, using a double-buffered speech memory.
- Adds a shadow control memory with a frame-aligned atomic commit, a per-entry idle pattern and a frame strobe, none of which the 8-stream 32-slot switch has.

Parameters:
- N_STREAMS, 8: number of serial input streams and of output streams (1..64).
- SLOTS, 32: time slots per frame (2..256, power of two).
- SLOT_BITS, 8: bits per slot (2..16).
- IDLE_PATTERN, 8'hFF: slot value driven for disabled or invalid connections; low SLOT_BITS bits used, zero-extended when SLOT_BITS > 8.

Ports:
- clk  in  1  Single clock; all logic on rising edge.
- reset  in  1  Synchronous, active-high reset.
- input_valid  in  1  Qualifies stream_in; frame bit counter advances only when high.
- stream_in  in  N_STREAMS  One serial bit per stream; bit i = stream i.
- control_write  in  1  Writes control_data into shadow entry control_addr.
- control_addr  in  clog2(N_STREAMS*SLOTS)  Entry index = out_stream*SLOTS + out_slot.
- control_data  in  16  [15] enable; [13:8] source stream; [7:0] source slot; [14] reserved.
- ctrl_commit  in  1  Pulse: copy shadow to active control at next frame boundary.
- commit_pending  out  1  High from ctrl_commit until the copy completes.
- frame_sync  out  1  One-cycle pulse when bit 0 of slot 0 is driven on stream_out.
- stream_out  out  N_STREAMS  Switched serial outputs, LSB first.

Behaviour:
- Reset: bit counter, bank select, frame_primed, commit_pending, frame_sync and stream_out all go to 0. Shadow and active control entries clear to 0, so every connection is disabled. Speech memory contents are don't-care.
- Reset asserted mid-frame aborts the frame and discards the pending commit. The next valid bit after reset is treated as bit 0 of slot 0.
- Bit counter: width clog2(SLOTS*SLOT_BITS); increments on each input_valid cycle and wraps to 0 after SLOTS*SLOT_BITS-1. Slot = counter / SLOT_BITS, bit = counter % SLOT_BITS.
- Input side: each stream has a shift register. On the last bit of a slot the assembled word is written to the write bank at address (stream, slot).
- Frame wrap: on the cycle the last bit of a frame is sampled, the bank select toggles and frame_primed is set.
- Output side: each output is a registered shift register with exactly one cycle of latency. The stream_out bit for frame position p appears the cycle after input bit p is sampled.
- At each slot start the output loads a prefetched word from the read bank (the previous frame), addressed by the active entry for that output and slot.
- The output loads IDLE_PATTERN instead when any of these holds: enable = 0, source stream >= N_STREAMS, source slot >= SLOTS, or frame_primed = 0.
- Net switching delay is exactly one frame plus one clock. Slot order may be arbitrary, and one source may be broadcast to many outputs.
- Stall: while input_valid = 0 the counter, shift registers and stream_out hold their values and frame_sync = 0.
- control_write updates the shadow copy only and never disturbs traffic. control_addr >= N_STREAMS*SLOTS is ignored.
- Commit: ctrl_commit sets commit_pending. The whole shadow copy moves to active at the frame wrap, so the first output slot of the next frame uses the new map; no frame ever mixes old and new maps. commit_pending clears on that same cycle.
- If input_valid = 0 and the counter = 0 while a commit is pending, the copy happens on the next cycle.
- ctrl_commit arriving on a wrap cycle is honoured at that wrap.
- control_write and commit on the same cycle: the write is included in the copy.

Test Plan:
- Identity map, stream 0 input pattern 32'h44332211 for two frames, slots 0..3 mapped to themselves (entry data 16'h8000..16'h8003) -> frame 1 out slots 0..3 = 11,22,33,44. Frame 0 outputs all FF (unprimed). frame_sync fires every 256 valid cycles.
- Cross-connect: entry 0 = 16'h8105 (stream 1, slot 5) with stream 1 slot 5 = 8'hA4 -> out stream 0 slot 0 = A4 one frame plus one clock later. Broadcast of the same source to 3 outputs gives identical bytes.
- Disabled/invalid: entry data 16'h0003, and 16'h8A00 with N_STREAMS = 8 -> those slots output IDLE_PATTERN FF.
- Atomic commit: new map written mid-frame with ctrl_commit at bit 100 -> frame output unchanged until wrap, new map from slot 0 of the next frame. commit_pending is high for exactly the intervening cycles.
- Stall: input_valid low for 7 cycles mid-slot -> stream_out holds. After resuming, the bytes equal the unstalled reference run.
- Mid-frame reset at bit 77 -> all outputs 0 and pending commit dropped. The first frame after reset outputs FF, and correct switching resumes in the second frame.
